// File: rtl/uart_ram_dump.sv
// Reads a block of program RAM and streams it out as 8N1 UART frames, LSB first.
// The CPU is held off through ask_for_ram for the whole dump and released without a reboot.
module uart_ram_dump #(
    parameter int CLKS_PER_BIT = 104,
    parameter int GRANT_CYCLES = 4
) (
    input  logic        clk_ram,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] length,
    output logic [15:0] raddr,
    input  logic [7:0]  rdata,
    output logic        ask_for_ram,
    output logic        serial_txd,
    output logic        busy,
    output logic        done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int WW = $clog2(GRANT_CYCLES + 1);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(GRANT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, GRANT, FETCH, LATCH, START, DATA, STOP, FIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] remain_q, remain_d;
    logic [15:0] raddr_q, raddr_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [WW-1:0] wait_q, wait_d;
    logic        txd_q, txd_d;
    logic        ask_q, ask_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    assign raddr       = raddr_q;
    assign serial_txd  = txd_q;
    assign ask_for_ram = ask_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // raddr is loaded on the way into FETCH so rdata is ready to capture in LATCH
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        raddr_d  = raddr_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        wait_d   = wait_q;
        txd_d    = txd_q;
        ask_d    = ask_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = length;
                    if (length == 16'd0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        ask_d   = 1'b1;
                        wait_d  = WAIT_LOAD;
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                if (wait_q == WW'(1)) begin
                    raddr_d = addr_q;
                    state_d = FETCH;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                shift_d = rdata;
                txd_d   = 1'b0;
                baud_d  = BAUD_LOAD;
                state_d = START;
            end
            START: begin
                if (baud_q == '0) begin
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = 3'd0;
                    baud_d  = BAUD_LOAD;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    remain_d = remain_q - 16'd1;
                    addr_d   = addr_q + 16'd1;
                    if (remain_q == 16'd1) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ask_d   = 1'b0;
                        state_d = FIN;
                    end else begin
                        raddr_d = addr_q + 16'd1;
                        state_d = FETCH;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 16'h0000;
            remain_q <= 16'h0000;
            raddr_q  <= 16'h0000;
            shift_q  <= 8'h00;
            bit_q    <= 3'd0;
            baud_q   <= '0;
            wait_q   <= '0;
            txd_q    <= 1'b1;
            ask_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            raddr_q  <= raddr_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            wait_q   <= wait_d;
            txd_q    <= txd_d;
            ask_q    <= ask_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_ram_dump.sv
// Directed bench for uart_ram_dump: a 1-cycle-latency RAM model, a sampling UART receiver
// and a scoreboard of expected (address, byte) pairs filled when each dump is requested.
module tb_uart_ram_dump;

    localparam int CPB = 4;
    localparam int GC  = 4;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk_ram;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic [15:0] raddr;
    logic [7:0]  rdata;
    logic        ask_for_ram;
    logic        serial_txd;
    logic        busy;
    logic        done;

    logic [7:0] mem [0:65535];
    exp_t       sb [$];
    int         compared = 0;
    int         mismatched = 0;

    uart_ram_dump #(.CLKS_PER_BIT(CPB), .GRANT_CYCLES(GC)) dut (
        .clk_ram     (clk_ram),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .raddr       (raddr),
        .rdata       (rdata),
        .ask_for_ram (ask_for_ram),
        .serial_txd  (serial_txd),
        .busy        (busy),
        .done        (done)
    );

    initial clk_ram = 1'b0;
    always #5 clk_ram = ~clk_ram;

    always @(posedge clk_ram) rdata <= mem[raddr];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queues the expected bytes for a dump, then pulses start; returns at the cycle-1 sample point.
    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] len);
        logic [15:0] a;
        a = base;
        for (int i = 0; i < int'(len); i++) begin
            sb.push_back('{addr: a, data: mem[a]});
            a = a + 16'd1;
        end
        base_addr = base;
        length    = len;
        start     = 1'b1;
        @(negedge clk_ram);
        start     = 1'b0;
        base_addr = 16'hDEAD;
        length    = 16'h0BAD;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (serial_txd !== 1'b0 && n < 300) begin
            @(negedge clk_ram);
            n++;
        end
    endtask

    // Called at the first low sample of a start bit; samples each bit in its second cycle.
    task automatic recv_frame(input bit poke);
        logic [7:0] b;
        exp_t       e;
        @(negedge clk_ram);
        checkOutput("start_bit", 32'(serial_txd), 32'd0);
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
            e = '{addr: 16'hxxxx, data: 8'hxx};
        end else begin
            e = sb.pop_front();
        end
        checkOutput("raddr", 32'(raddr), 32'(e.addr));
        for (int i = 0; i < 8; i++) begin
            if (poke && i == 3) begin
                start     = 1'b1;
                base_addr = 16'h1234;
                length    = 16'd5;
                @(negedge clk_ram);
                start     = 1'b0;
                repeat (CPB - 1) @(negedge clk_ram);
            end else begin
                repeat (CPB) @(negedge clk_ram);
            end
            b[i] = serial_txd;
        end
        checkOutput("data_byte", 32'(b), 32'(e.data));
        repeat (CPB) @(negedge clk_ram);
        checkOutput("stop_bit", 32'(serial_txd), 32'd1);
        checkOutput("ask_in_frame", 32'(ask_for_ram), 32'd1);
    endtask

    task automatic run_dump(input logic [15:0] base, input logic [15:0] len, input int poke_frame);
        int n;
        applyStimulus(base, len);
        checkOutput("busy_cycle1", 32'(busy), 32'd1);
        checkOutput("ask_cycle1", 32'(ask_for_ram), 32'd1);
        wait_fall(n);
        checkOutput("first_fall_cycle", 32'(n + 1), 32'(GC + 3));
        for (int f = 0; f < int'(len); f++) begin
            recv_frame(f == poke_frame);
            if (f != int'(len) - 1) begin
                wait_fall(n);
                checkOutput("gap_cycles", 32'(n - 3), 32'd2);
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk_ram);
            n++;
        end
        checkOutput("done_latency", 32'(n), 32'd3);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("ask_at_done", 32'(ask_for_ram), 32'd0);
        @(negedge clk_ram);
        checkOutput("done_single", 32'(done), 32'd0);
        checkOutput("ask_after_done", 32'(ask_for_ram), 32'd0);
        checkOutput("txd_idle", 32'(serial_txd), 32'd1);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int cnt;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        reset = 1'b1;
        start = 1'b0;
        base_addr = 16'h0000;
        length = 16'h0000;
        repeat (3) @(negedge clk_ram);
        checkOutput("rst_raddr", 32'(raddr), 32'h0000);
        checkOutput("rst_ask", 32'(ask_for_ram), 32'd0);
        checkOutput("rst_txd", 32'(serial_txd), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk_ram);

        $display("[TB] case 1: single byte 0xA5");
        mem[16'h0600] = 8'hA5;
        run_dump(16'h0600, 16'd1, -1);

        $display("[TB] case 2: three bytes");
        mem[16'h0600] = 8'h00;
        mem[16'h0601] = 8'hFF;
        mem[16'h0602] = 8'h3C;
        run_dump(16'h0600, 16'd3, -1);

        $display("[TB] case 3: address wrap");
        mem[16'hFFFE] = 8'h81;
        mem[16'hFFFF] = 8'h7E;
        mem[16'h0000] = 8'hC3;
        run_dump(16'hFFFE, 16'd3, -1);

        $display("[TB] case 4: zero length");
        applyStimulus(16'h0700, 16'd0);
        checkOutput("len0_done", 32'(done), 32'd1);
        checkOutput("len0_busy", 32'(busy), 32'd0);
        checkOutput("len0_ask", 32'(ask_for_ram), 32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_ram);
            if (ask_for_ram !== 1'b0 || serial_txd !== 1'b1 || done !== 1'b0) cnt++;
        end
        checkOutput("len0_quiet", 32'(cnt), 32'd0);

        $display("[TB] case 5: start pulsed during byte 2");
        run_dump(16'h0600, 16'd3, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_ram);
            if (ask_for_ram !== 1'b0 || busy !== 1'b0) cnt++;
        end
        checkOutput("poke_ignored", 32'(cnt), 32'd0);

        $display("[TB] case 6: reset during DATA");
        mem[16'h0020] = 8'h00;
        mem[16'h0021] = 8'h00;
        applyStimulus(16'h0020, 16'd2);
        wait_fall(n);
        repeat (15) @(negedge clk_ram);
        checkOutput("pre_rst_txd", 32'(serial_txd), 32'd0);
        reset = 1'b1;
        @(negedge clk_ram);
        checkOutput("midrst_txd", 32'(serial_txd), 32'd1);
        checkOutput("midrst_ask", 32'(ask_for_ram), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        sb.delete();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_ram);
            if (done !== 1'b0 || serial_txd !== 1'b1) cnt++;
        end
        checkOutput("postrst_quiet", 32'(cnt), 32'd0);
        mem[16'h0010] = 8'h96;
        run_dump(16'h0010, 16'd1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
